prbs_word_checker: RTL

// - Self-synchronising, multi-polynomial PRBS checker for parallel words from the GT RX path (rxusrclk2 domain).
// - Parametrised successor to the fixed 32-bit PRBS7 loop: runtime PRBS7/15/23/31 select, any word width, lock FSM, saturating counters.
// - Sits between the transceiver RX data port and the ILA/status logic; feeds link-quality monitoring.

---
 rtl/prbs_word_checker.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/prbs_word_checker.sv
// Self-synchronising PRBS7/15/23/31 checker for parallel RX words, LSB first.
// Ports: clk, reset (sync, active-low), din/din_valid word input, prbs_sel
// polynomial select, pol_inv (used only with PRBS_CHK_INV_EN defined),
// clr_cnt counter clear; outputs locked, err_bits, word_err, err_count,
// word_count. Define PRBS_CHK_INV_EN to enable input polarity inversion.
module prbs_word_checker #(
  parameter int WORDWIDTH  = 32,
  parameter int CNTWIDTH   = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic [1:0]           prbs_sel,
  input  logic                 pol_inv,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic [WORDWIDTH-1:0] err_bits,
  output logic                 word_err,
  output logic [CNTWIDTH-1:0]  err_count,
  output logic [CNTWIDTH-1:0]  word_count
);

  localparam int SW  = WORDWIDTH + 31;
  localparam int PCW = $clog2(WORDWIDTH + 1);
  localparam int AW  = ((CNTWIDTH > PCW) ? CNTWIDTH : PCW) + 1;

  localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  logic [WORDWIDTH-1:0] din_c;
  logic [30:0]          hist;
  logic [30:0]          hist_nx;
  logic [SW-1:0]        s;
  logic [WORDWIDTH-1:0] exp_w;
  logic [WORDWIDTH-1:0] chk_bits;
  logic                 zero_w;
  logic [1:0]           sel_q;
  logic                 sel_chg;
  logic                 chk_vld;

  state_t               state_q;
  state_t               state_nx;
  logic [7:0]           run_q;
  logic [7:0]           run_nx;
  logic [7:0]           run_inc;

  logic [PCW-1:0]       pop;
  logic [AW-1:0]        err_sum;
  logic [CNTWIDTH-1:0]  err_nx;
  logic [CNTWIDTH-1:0]  wc_nx;
  logic                 cnt_en;

  // Input conditioning and configuration change detect.
`ifdef PRBS_CHK_INV_EN
  logic inv_q;

  assign din_c   = din ^ {WORDWIDTH{pol_inv}};
  assign sel_chg = (prbs_sel != sel_q) ||
                   (pol_inv != inv_q);

  always_ff @(posedge clk) begin
    inv_q <= pol_inv;
  end
`else
  logic unused_pol;

  assign unused_pol = pol_inv;
  assign din_c      = din;
  assign sel_chg    = (prbs_sel != sel_q);
`endif

  // Reset loads the live select so the first
  // word after reset is not seen as a change.
  always_ff @(posedge clk) begin
    sel_q <= prbs_sel;
  end

  // Received stream: history below, new word above.
  assign s       = {din_c, hist};
  assign hist_nx = s[SW-1:WORDWIDTH];

  // Bit i of the word sits at stream index 31+i.
  always_comb begin
    exp_w = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      unique case (sel_q)
        2'd0: exp_w[i] = s[i+24] ^ s[i+25];
        2'd1: exp_w[i] = s[i+16] ^ s[i+17];
        2'd2: exp_w[i] = s[i+8]  ^ s[i+13];
        2'd3: exp_w[i] = s[i]    ^ s[i+3];
      endcase
    end
  end

  // All-zero word on all-zero history would
  // self-check clean; flag it as fully wrong.
  assign zero_w   = (din_c == '0) && (hist == '0);
  assign chk_bits = zero_w ? '1 : (din_c ^ exp_w);

  // Check stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist     <= '0;
      err_bits <= '0;
      word_err <= 1'b0;
      chk_vld  <= 1'b0;
    end else begin
      chk_vld <= din_valid && !sel_chg;
      if (sel_chg) begin
        hist <= '0;
      end else if (din_valid) begin
        hist     <= hist_nx;
        err_bits <= chk_bits;
        word_err <= |chk_bits;
      end
    end
  end

  // Lock FSM: state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      run_q   <= '0;
    end else begin
      state_q <= state_nx;
      run_q   <= run_nx;
    end
  end

  assign run_inc = run_q + 8'd1;

  // Lock FSM: next state.
  always_comb begin
    state_nx = state_q;
    run_nx   = run_q;
    if (sel_chg) begin
      state_nx = HUNT;
      run_nx   = '0;
    end else if (chk_vld) begin
      unique case (state_q)
        HUNT: begin
          if (word_err) begin
            run_nx = '0;
          end else if (run_inc == LOCK_N) begin
            state_nx = LOCKED;
            run_nx   = '0;
          end else begin
            run_nx = run_inc;
          end
        end
        LOCKED: begin
          if (!word_err) begin
            run_nx = '0;
          end else if (run_inc == UNLOCK_N) begin
            state_nx = HUNT;
            run_nx   = '0;
          end else begin
            run_nx = run_inc;
          end
        end
      endcase
    end
  end

  // Lock FSM: outputs.
  always_comb begin
    locked = (state_q == LOCKED);
  end

  // Error popcount of the registered mask.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      pop = pop + PCW'(err_bits[i]);
    end
  end

  assign cnt_en  = chk_vld && !sel_chg &&
                   (state_q == LOCKED);
  assign err_sum = AW'(err_count) + AW'(pop);
  assign err_nx  = (|err_sum[AW-1:CNTWIDTH]) ?
                   '1 : err_sum[CNTWIDTH-1:0];
  assign wc_nx   = (&word_count) ?
                   word_count : word_count + 1'b1;

  // Saturating counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (clr_cnt) begin
      err_count  <= '0;
      word_count <= '0;
    end else if (cnt_en) begin
      err_count  <= err_nx;
      word_count <= wc_nx;
    end
  end

endmodule
